adder_chunk_serial: RTL and testbench
=====================================

Name: adder_chunk_serial

Overview:
- Parametrised multi-cycle ripple-carry adder for the datapath: adds two WIDTH-bit operands plus carry-in, CHUNK bits per cycle.
- A registered carry links successive chunks.
- Trades latency for area so wide sums (phase accumulators, sample mixing) reuse one narrow ripple-carry slice.
- Latency-insensitive val/rdy handshakes on input and output.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; must be ≥1.
- NCHUNKS (localparam), WIDTH/CHUNK, cycles spent computing.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- istream_val  input  1  operands valid
- istream_rdy  output  1  block can accept operands
- in0  input  WIDTH  operand A
- in1  input  WIDTH  operand B
- cin  input  1  carry-in
- ostream_val  output  1  result valid
- ostream_rdy  input  1  consumer accepts result
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry-out

Behaviour:
- One clock; reset is synchronous and active-high.
- States: IDLE, CALC, DONE.
- Reset values, effective on the edge where reset=1:
  - state=IDLE, istream_rdy=1, ostream_val=0.
  - sum=0, cout=0, chunk index=0, carry register=0.
- IDLE:
  - istream_rdy=1.
  - On an edge with istream_val=1: latch in0, in1, cin; carry register←cin; index←0; clear sum register; go to CALC.
- CALC:
  - istream_rdy=0, ostream_val=0.
  - Each cycle, the combinational chunk adder sums in0[idx*CHUNK+:CHUNK] + in1[same] + carry register.
  - On the edge: write that slice of the sum register, carry register←chunk carry-out, idx←idx+1.
  - When idx==NCHUNKS-1 at the edge: go to DONE; cout←final chunk carry.
- DONE:
  - ostream_val=1; sum/cout held stable until accepted.
  - On an edge with ostream_rdy=1: go to IDLE.
  - No accept of new operands in the same cycle; istream_rdy=0 in DONE.
- Latency: operands accepted at edge k → ostream_val=1 from edge k+NCHUNKS.
- Throughput: one operation per NCHUNKS+2 cycles when ostream_rdy=1.
- Arithmetic: {cout,sum} = in0 + in1 + cin, modulo 2^(WIDTH+1). Full wrap-around; no saturation.
- Boundaries:
  - Input changes after acceptance are ignored (operands are latched).
  - istream_val during CALC/DONE is ignored; the producer must hold it.
  - ostream_rdy=0 in DONE stalls indefinitely with outputs stable.
  - Reset in any state (including mid-CALC) forces IDLE and discards the partial result.
  - Reset overrides a simultaneous handshake.
  - CHUNK==WIDTH gives NCHUNKS=1: a single CALC cycle.
- sum/cout outside DONE hold their last value; checkers must sample only when ostream_val=1.

Optional Feature:
- Macro: ADDER_CHUNK_SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands.
  - When sub=1: compute in0 + ~in1 + ~cin, i.e. in0 - in1 - cin.
  - cout=1 means no borrow.
  - When sub=0: behaviour identical to the undefined case.
- Undefined:
  - No sub port; addition only.

Decomposition:
- Package adder_chunk_serial_pkg holds:
  - state enum (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - function computing NCHUNKS;
  - index-width helper $clog2(NCHUNKS) with a minimum of 1.
- One sub-module: adder_ripple_carry_chunk.
  - Combinational, parameter CHUNK.
  - Chain of full adders built from gates (in0, in1, cin → sum, cout), matching the existing gate-level adder style.
- The FSM and registers live in the top module.

Test Plan (WIDTH=16, CHUNK=4, ostream_rdy=1 unless stated):
- 0x0001+0x0001, cin=0 → sum=0x0002, cout=0; ostream_val rises exactly 4 cycles after the accept edge.
- 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1 (carry ripples through all 4 chunks). 0x0FFF+0x0000, cin=1 → sum=0x1000, cout=0.
- 0xFFFF+0xFFFF, cin=1 → sum=0xFFFF, cout=1. Hold ostream_rdy=0 for 5 cycles → ostream_val stays 1 and the result is stable; accepted on the first cycle ostream_rdy=1; istream_rdy returns 1 the next cycle.
- Inputs changed mid-CALC (0x1234+0x1111 accepted, then in0 driven to 0xFFFF) → sum=0x2345. istream_val held during CALC → no second accept until IDLE.
- Reset asserted at the 2nd CALC cycle of 0xFFFF+0x0001 → next cycle IDLE, istream_rdy=1, ostream_val=0. A following 0x0003+0x0004 gives sum=0x0007, cout=0.
- 50 random {in0,in1,cin} checked against the 17-bit reference sum. With ADDER_CHUNK_SERIAL_SUB_EN, also: 0x0005-0x0007 (sub=1, cin=0) → sum=0xFFFE, cout=0; 0x0007-0x0005 → sum=0x0002, cout=1.

Source files
------------

// File: rtl/adder_chunk_serial_pkg.sv
// Shared types and sizing helpers for the chunk-serial ripple-carry adder.
package adder_chunk_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nchunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // An index register needs at least one bit, even when NCHUNKS is 1.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_chunk_serial_chunk.sv
// Combinational CHUNK-bit ripple-carry slice built from gate-level full adders.
module adder_ripple_carry_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] in0,
    input  logic [CHUNK-1:0] in1,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic prop;
        assign prop       = in0[i] ^ in1[i];
        assign sum[i]     = prop ^ carry[i];
        assign carry[i+1] = (in0[i] & in1[i]) | (prop & carry[i]);
    end

    assign cout = carry[CHUNK];

endmodule

// File: rtl/adder_chunk_serial.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock with a registered carry.
// Optional subtract mode under ADDER_CHUNK_SERIAL_SUB_EN (adds a 'sub' input).
//
// state | meaning
// IDLE  | ready for operands
// CALC  | one chunk summed per cycle, low chunk first
// DONE  | result presented until the consumer takes it
module adder_chunk_serial
    import adder_chunk_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             cin,
`ifdef ADDER_CHUNK_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NCHUNKS = nchunks(WIDTH, CHUNK);
    localparam int IDXW    = idx_width(NCHUNKS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNKS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

    assign chunk_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign chunk_b = b_q[int'(idx_q)*CHUNK +: CHUNK];

    adder_ripple_carry_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .in0  (chunk_a),
        .in1  (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (istream_val) begin
                    a_d     = in0;
`ifdef ADDER_CHUNK_SERIAL_SUB_EN
                    // Subtraction reuses the adder: a + ~b + ~cin == a - b - cin.
                    b_d     = sub ? ~in1 : in1;
                    carry_d = sub ? ~cin : cin;
`else
                    b_d     = in1;
                    carry_d = cin;
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum;
                carry_d = chunk_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign istream_rdy = (state_q == IDLE);
    assign ostream_val = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;

endmodule

// File: tb/tb_adder_chunk_serial.sv
// Scoreboard bench for adder_chunk_serial (WIDTH=16, CHUNK=4): directed vectors plus a random sweep.
module tb_adder_chunk_serial;

    logic        clk = 1'b0;
    logic        reset;
    logic        istream_val;
    logic        istream_rdy;
    logic [15:0] in0, in1;
    logic        cin;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [15:0] sum;
    logic        cout;
`ifdef ADDER_CHUNK_SERIAL_SUB_EN
    logic        sub;
`endif

    adder_chunk_serial #(.WIDTH(16), .CHUNK(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .in0         (in0),
        .in1         (in1),
        .cin         (cin),
`ifdef ADDER_CHUNK_SERIAL_SUB_EN
        .sub         (sub),
`endif
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .sum         (sum),
        .cout        (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Drives one operand set; returns 1ns after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic ec, input bit push);
        int n = 0;
        exp_t e;
        while (!istream_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!istream_rdy) timeout_fail("send_wait_rdy");
        in0 = a;
        in1 = b;
        cin = c;
        istream_val = 1'b1;
        if (push) begin
            e.s = es;
            e.c = ec;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        istream_val = 1'b0;
    endtask

    task automatic wait_val();
        int n = 0;
        while (!ostream_val && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ostream_val) timeout_fail("wait_ostream_val");
    endtask

    // Monitor: any handshake on the output side pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && ostream_val && ostream_rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got sum=%0h cout=%0b expected none", sum, cout);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 32'(sum), 32'(e.s));
                    check("cout", 32'(cout), 32'(e.c));
                end
            end
        end
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] ref_sum;
        int          n;

        reset       = 1'b1;
        istream_val = 1'b0;
        in0         = '0;
        in1         = '0;
        cin         = 1'b0;
        ostream_rdy = 1'b1;
`ifdef ADDER_CHUNK_SERIAL_SUB_EN
        sub         = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_istream_rdy", 32'(istream_rdy), 32'd1);
        check("rst_ostream_val", 32'(ostream_val), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);

        // Latency: valid appears on the 4th edge after acceptance.
        send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("latency_val", 32'(ostream_val), (i == 4) ? 32'd1 : 32'd0);
        end

        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        send(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b1);

        // Output stall with outputs held.
        send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        ostream_rdy = 1'b0;
        wait_val();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_val", 32'(ostream_val), 32'd1);
            check("stall_sum", 32'(sum), 32'h0000FFFF);
            check("stall_cout", 32'(cout), 32'd1);
        end
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("post_accept_istream_rdy", 32'(istream_rdy), 32'd1);
        check("post_accept_ostream_val", 32'(ostream_val), 32'd0);

        // Operands latched; istream_val held through CALC/DONE is not taken.
        send(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b1);
        in0 = 16'hFFFF;
        istream_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("busy_istream_rdy", 32'(istream_rdy), 32'd0);
        end
        send(16'hFFFF, 16'h1111, 1'b0, 16'h1110, 1'b1, 1'b1);

        // Reset mid-CALC discards the partial result.
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_istream_rdy", 32'(istream_rdy), 32'd1);
        check("midrst_ostream_val", 32'(ostream_val), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midrst_quiet_val", 32'(ostream_val), 32'd0);
        end
        send(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b1);

        for (int i = 0; i < 50; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            send(ra, rb, rc, ref_sum[15:0], ref_sum[16], 1'b1);
        end

`ifdef ADDER_CHUNK_SERIAL_SUB_EN
        sub = 1'b1;
        send(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b1);
        sub = 1'b0;
        send(16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0, 1'b1);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeout_fail("drain_scoreboard");
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
